// File: rtl/riscv_pkg.sv
// Shared definitions for the branch redirect path: funct3 encodings,
// redirect FSM states and the default datapath width.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 64;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } brs_state_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation: (a, b, funct3) -> taken.
// funct3 values 010/011 are not branch conditions and evaluate as not taken.
module branch_compare
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   output logic            taken
);

   // Select the comparison named by funct3
   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = ($signed(a) <  $signed(b));
         F3_BGE:  taken = ($signed(a) >= $signed(b));
         F3_BLTU: taken = (a <  b);
         F3_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves ID/RF branches and drives the IF redirect interface
// (pc_branch/select), squashing wrong-path instructions with flush and
// keeping saturating branch/taken statistics.
module branch_redirect_unit
   import riscv_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic             id_branch,
   input  logic [3:0]       id_func,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_extended,
   input  logic [XLEN-1:0]  id_read_data_1,
   input  logic [XLEN-1:0]  id_read_data_2,
   output logic [XLEN-1:0]  pc_branch,
   output logic             select,
   output logic             flush,
   output logic             busy,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

   brs_state_t      state;
   brs_state_t      state_next;
   logic [FC_W-1:0] flush_cnt;
   logic            accept;
   logic            taken;
   logic            redirect;
   logic [XLEN-1:0] target;
   logic            func_unused;

   // id_func[3] carries no branch information
   assign func_unused = id_func[3];

   branch_compare #(.XLEN(XLEN)) u_compare (
      .a      (id_read_data_1),
      .b      (id_read_data_2),
      .funct3 (id_func[2:0]),
      .taken  (taken)
   );

   assign accept   = (state == IDLE) && id_valid && id_branch;
   assign redirect = accept && taken;
   assign target   = id_pc + (id_extended << 1);
   assign busy     = (state != IDLE);

   // Next-state logic of the redirect/flush sequence
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (redirect) state_next = REDIRECT;
         REDIRECT: state_next = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
         FLUSH:    if (flush_cnt == '0) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // State register and flush down-counter (loaded during REDIRECT)
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         flush_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == REDIRECT)
            flush_cnt <= FC_LOAD;
         else if (state == FLUSH && flush_cnt != '0)
            flush_cnt <= flush_cnt - FC_W'(1);
      end
   end

   // Registered IF-facing outputs; pc_branch keeps its last target
   always_ff @(posedge clk) begin
      if (!reset) begin
         select    <= 1'b0;
         flush     <= 1'b0;
         pc_branch <= '0;
      end else begin
         select <= (state_next == REDIRECT);
         flush  <= (state_next != IDLE);
         if (redirect)
            pc_branch <= target;
      end
   end

   // Saturating statistics, advanced only on accepted branches
   always_ff @(posedge clk) begin
      if (!reset) begin
         branch_count <= '0;
         taken_count  <= '0;
      end else begin
         if (accept && branch_count != '1)
            branch_count <= branch_count + CNT_W'(1);
         if (redirect && taken_count != '1)
            taken_count <= taken_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: one instance with the default
// flush length and one with FLUSH_CYCLES=0.
module tb_branch_redirect_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_valid1, id_branch;
   logic [3:0]  id_func;
   logic [63:0] id_pc, id_extended, id_read_data_1, id_read_data_2;

   logic [63:0] pc_branch, pc_branch1;
   logic        select, flush, busy, select1, flush1, busy1;
   logic [15:0] branch_count, taken_count, branch_count1, taken_count1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   branch_redirect_unit #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch),
      .id_func(id_func), .id_pc(id_pc), .id_extended(id_extended),
      .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
      .pc_branch(pc_branch), .select(select), .flush(flush), .busy(busy),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   branch_redirect_unit #(.XLEN(64), .FLUSH_CYCLES(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid1), .id_branch(id_branch),
      .id_func(id_func), .id_pc(id_pc), .id_extended(id_extended),
      .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
      .pc_branch(pc_branch1), .select(select1), .flush(flush1), .busy(busy1),
      .branch_count(branch_count1), .taken_count(taken_count1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // advance one edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic br, input logic [3:0] f,
                        input logic [63:0] pc, input logic [63:0] ext,
                        input logic [63:0] a, input logic [63:0] b);
      id_valid       = v;
      id_branch      = br;
      id_func        = f;
      id_pc          = pc;
      id_extended    = ext;
      id_read_data_1 = a;
      id_read_data_2 = b;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 4'h0, 64'h0, 64'h0, 64'h0, 64'h0);
   endtask

   initial begin
      reset = 1'b0;
      id_valid1 = 1'b0;
      idle_in();
      step(); step();
      check("rst_select", select, 0);
      check("rst_flush", flush, 0);
      check("rst_busy", busy, 0);
      check("rst_pc_branch", pc_branch, 0);
      check("rst_branch_count", branch_count, 0);
      check("rst_taken_count", taken_count, 0);
      reset = 1'b1;

      // BEQ taken, target 0x100 + 8*2
      drive(1'b1, 1'b1, 4'b0000, 64'h100, 64'd8, 64'd5, 64'd5);
      step();
      check("beq_select", select, 1);
      check("beq_pc_branch", pc_branch, 64'h110);
      check("beq_flush", flush, 1);
      check("beq_busy", busy, 1);
      check("beq_taken_count", taken_count, 1);
      // a taken branch presented while busy must be ignored
      drive(1'b1, 1'b1, 4'b0000, 64'h300, 64'd4, 64'd1, 64'd1);
      step();
      check("flush1_select", select, 0);
      check("flush1_flush", flush, 1);
      check("flush1_pc_hold", pc_branch, 64'h110);
      step();
      check("flush2_flush", flush, 1);
      check("flush2_busy", busy, 1);
      idle_in();
      step();
      check("post_flush_flush", flush, 0);
      check("post_flush_busy", busy, 0);
      check("ignored_branch_count", branch_count, 1);
      check("ignored_taken_count", taken_count, 1);

      // BNE with equal operands: not taken
      drive(1'b1, 1'b1, 4'b0001, 64'h100, 64'd8, 64'd7, 64'd7);
      step();
      idle_in();
      check("bne_select", select, 0);
      check("bne_flush", flush, 0);
      check("bne_busy", busy, 0);
      check("bne_branch_count", branch_count, 2);
      check("bne_taken_count", taken_count, 1);

      // BLT signed -1 < 1: taken
      drive(1'b1, 1'b1, 4'b0100, 64'h40, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      idle_in();
      check("blt_select", select, 1);
      check("blt_pc_branch", pc_branch, 64'h44);
      check("blt_taken_count", taken_count, 2);
      step(); step(); step();
      check("blt_done_busy", busy, 0);

      // BLTU same operands: 0xFFFF... < 1 is false
      drive(1'b1, 1'b1, 4'b0110, 64'h40, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      idle_in();
      check("bltu_select", select, 0);
      check("bltu_branch_count", branch_count, 4);
      check("bltu_taken_count", taken_count, 2);

      // BGEU equal operands, negative immediate: 0x200 - 8
      drive(1'b1, 1'b1, 4'b0111, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 64'd9, 64'd9);
      step();
      idle_in();
      check("bgeu_select", select, 1);
      check("bgeu_pc_branch", pc_branch, 64'h1F8);
      check("bgeu_taken_count", taken_count, 3);
      step(); step(); step();

      // funct3 010: counted, never taken
      drive(1'b1, 1'b1, 4'b0010, 64'h0, 64'd4, 64'd3, 64'd3);
      step();
      check("f3_010_select", select, 0);
      check("f3_010_branch_count", branch_count, 6);
      // valid non-branch: not counted
      drive(1'b1, 1'b0, 4'b0000, 64'h0, 64'd4, 64'd3, 64'd3);
      step();
      idle_in();
      check("nonbranch_select", select, 0);
      check("nonbranch_branch_count", branch_count, 6);

      // target wraps modulo 2^64
      drive(1'b1, 1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'd0, 64'd0);
      step();
      idle_in();
      check("wrap_pc_branch", pc_branch, 64'h10);
      check("wrap_select", select, 1);
      step();
      check("wrap_f1_flush", flush, 1);
      step();
      // second FLUSH cycle: assert reset and present a branch
      reset = 1'b0;
      drive(1'b1, 1'b1, 4'b0000, 64'h0, 64'd4, 64'd1, 64'd1);
      step();
      check("midrst_select", select, 0);
      check("midrst_flush", flush, 0);
      check("midrst_busy", busy, 0);
      check("midrst_branch_count", branch_count, 0);
      check("midrst_taken_count", taken_count, 0);
      check("midrst_pc_branch", pc_branch, 0);
      reset = 1'b1;

      // back-to-back not-taken branches, one per cycle
      drive(1'b1, 1'b1, 4'b0001, 64'h0, 64'd4, 64'd7, 64'd7);
      step(); step(); step();
      check("b2b_branch_count", branch_count, 3);
      check("b2b_select", select, 0);
      for (int unsigned i = 0; i < 65531; i++) step();
      check("sat_pre_branch_count", branch_count, 16'hFFFE);
      step();
      check("sat_hit_branch_count", branch_count, 16'hFFFF);
      step(); step();
      check("sat_hold_branch_count", branch_count, 16'hFFFF);
      check("sat_taken_count", taken_count, 0);
      idle_in();

      // FLUSH_CYCLES=0: busy exactly one cycle per redirect
      step();
      id_valid1 = 1'b1;
      drive(1'b0, 1'b1, 4'b0000, 64'h80, 64'd1, 64'd2, 64'd2);
      step();
      check("fc0_busy_a", busy1, 1);
      check("fc0_select_a", select1, 1);
      check("fc0_flush_a", flush1, 1);
      check("fc0_pc_branch", pc_branch1, 64'h82);
      step();
      check("fc0_busy_b", busy1, 0);
      check("fc0_flush_b", flush1, 0);
      check("fc0_select_b", select1, 0);
      step();
      id_valid1 = 1'b0;
      check("fc0_busy_c", busy1, 1);
      check("fc0_taken_count", taken_count1, 2);
      check("fc0_branch_count", branch_count1, 2);
      check("fc0_other_untouched", branch_count, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
